// File: rtl/mem_b_readback.sv
// mem_b_readback: reads words 0..len-1 from memory B and streams them out.
// Flow-through 2-entry skid FIFO: a returning word is shown on the stream in
// its return cycle when the FIFO is empty, else it queues behind the head.
// Optional feature macro: CHECKSUM_EN adds chk_out, the running sum of words
// transferred in the current readback.
module mem_b_readback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_out
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [ADDR_W:0]             r_len_q;
    logic [ADDR_W:0]             r_rd_cnt;
    logic [ADDR_W:0]             r_em_cnt;
    logic                        r_inflight;
    logic [1:0][DATA_W-1:0]      r_buf;
    logic                        r_wp;
    logic                        r_rp;
    logic [1:0]                  r_occ;

    logic [ADDR_W:0]             w_len_clamp;
    logic [ADDR_W:0]             w_em_nxt;
    logic [1:0]                  w_pend;
    logic                        w_start_acc;
    logic                        w_head_vld;
    logic                        w_bypass;
    logic                        w_xfer;
    logic                        w_push;
    logic                        w_pop;

    assign w_len_clamp = (len > DEPTH) ? DEPTH : len;
    assign w_em_nxt    = r_em_cnt + 1'b1;
    // Words already committed to the buffer: stored plus the one returning now.
    assign w_pend      = r_occ + {1'b0, r_inflight};
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign mem_addr    = r_rd_cnt[ADDR_W-1:0];

    // Stream head: FIFO entry if any, else the word returning this cycle.
    assign w_head_vld = (r_occ != 2'd0);
    assign w_bypass   = !w_head_vld && r_inflight;
    assign out_valid  = w_head_vld || w_bypass;
    assign out_data   = w_head_vld ? r_buf[r_rp] : (w_bypass ? mem_rdata : '0);
    assign w_xfer     = out_valid && out_ready;
    // A returning word is stored unless it is consumed straight through.
    assign w_push     = r_inflight && !(w_bypass && out_ready);
    assign w_pop      = w_xfer && w_head_vld;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, read issue and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                busy   = 1'b1;
                // Never issue a read whose data could find the FIFO full.
                mem_re = (r_rd_cnt < r_len_q) && (w_pend < 2'd2);
                if (w_xfer && (w_em_nxt == r_len_q)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Length capture and read/emit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_q  <= '0;
            r_rd_cnt <= '0;
            r_em_cnt <= '0;
        end else if (w_start_acc) begin
            r_len_q  <= w_len_clamp;
            r_rd_cnt <= '0;
            r_em_cnt <= '0;
        end else begin
            if (mem_re) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_xfer) r_em_cnt <= w_em_nxt;
        end
    end

    // Read-in-flight flag and skid FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_buf      <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_inflight <= mem_re;
            if (w_push) begin
                r_buf[r_wp] <= mem_rdata;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] r_chk;

    assign chk_out = r_chk;

    // Running sum of transferred words, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst)              r_chk <= '0;
        else if (w_start_acc) r_chk <= '0;
        else if (w_xfer)      r_chk <= r_chk + out_data;
    end
`endif

endmodule

// File: tb/tb_mem_b_readback.sv
// Directed bench for mem_b_readback: a table of readback vectors plus
// hand-written reset-mid-transfer and checksum sequences.
module tb_mem_b_readback;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] chk_out;
`endif

    mem_b_readback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
`ifdef CHECKSUM_EN
        , .chk_out(chk_out)
`endif
    );

    always #5 clk = ~clk;

    // Memory B model: synchronous read, data one cycle after mem_re.
    logic [DATA_W-1:0] mem [8];
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int mode;       // 0: ready always 1; 1: ready pattern 1,0,0,1,0,0...
        int mid;        // 1: pulse a stray start (len=1) at cycle 5
        int exp_words;
        int exp_first;  // cycle of first out_valid, start cycle = 0; -1 none
        int exp_done;   // cycle of done; -1 means "cycle after last transfer"
    } vec_t;

    function automatic logic rdy(input int mode, input int c);
        return (mode == 0) ? 1'b1 : ((c % 3) == 0);
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int nwords = 0, first = -1, done_c = -1, ndone = 0;
        int issued = 0, xfers = 0, ovf = 0, stab = 0, busy_e = 0, last_x = -1;
        int hits[8];
        logic [DATA_W-1:0] pv_data = '0;
        bit pstall = 0;
        bit fin = 0;
        for (int a = 0; a < 8; a++) hits[a] = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1;
                len   = 4'(v.len);
            end else begin
                start = (v.mid != 0) && (c == 5);
                if (start) len = 4'd1;
            end
            out_ready = rdy(v.mode, c);
            #1;
            if (busy !== ((c >= 1) && (done_c < 0))) busy_e++;
            if (mem_re) begin
                if (issued - xfers >= 2) ovf++;
                hits[mem_addr]++;
                issued++;
            end
            if (pstall && (!out_valid || out_data !== pv_data)) stab++;
            if (out_valid && first < 0) first = c;
            if (out_valid && out_ready) begin
                chk($sformatf("v%0d word%0d", id, nwords), int'(out_data),
                    (nwords < 8) ? int'(mem[nwords]) : -1);
                nwords++;
                xfers++;
                last_x = c;
            end
            pstall  = out_valid && !out_ready;
            pv_data = out_data;
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 2) fin = 1;
        end
        start = 1'b0;
        if (!fin) chk($sformatf("v%0d timeout", id), 0, 1);
        chk($sformatf("v%0d word count", id), nwords, v.exp_words);
        chk($sformatf("v%0d first valid cycle", id), first, v.exp_first);
        chk($sformatf("v%0d done pulses", id), ndone, 1);
        chk($sformatf("v%0d done cycle", id), done_c,
            (v.exp_done >= 0) ? v.exp_done : last_x + 1);
        for (int a = 0; a < 8; a++)
            chk($sformatf("v%0d reads addr%0d", id, a), hits[a], (a < v.exp_words) ? 1 : 0);
        chk($sformatf("v%0d read with full buffer", id), ovf, 0);
        chk($sformatf("v%0d stall hold", id), stab, 0);
        chk($sformatf("v%0d busy", id), busy_e, 0);
        chk($sformatf("v%0d valid after done", id), int'(out_valid), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int xf;
        for (int i = 0; i < 8; i++) mem[i] = 8'(11 * (i + 1));

        vecs[0] = '{len: 4, mode: 0, mid: 0, exp_words: 4, exp_first: 2,  exp_done: 6};
        vecs[1] = '{len: 8, mode: 1, mid: 0, exp_words: 8, exp_first: 2,  exp_done: -1};
        vecs[2] = '{len: 0, mode: 0, mid: 0, exp_words: 0, exp_first: -1, exp_done: 1};
        vecs[3] = '{len: 9, mode: 0, mid: 1, exp_words: 8, exp_first: 2,  exp_done: 10};
        vecs[4] = '{len: 8, mode: 0, mid: 0, exp_words: 8, exp_first: 2,  exp_done: 10};
        vecs[5] = '{len: 5, mode: 1, mid: 0, exp_words: 5, exp_first: 2,  exp_done: -1};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset mem_re", int'(mem_re), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in mid-transfer after two of six words.
        @(negedge clk);
        start = 1'b1;
        len = 4'd6;
        out_ready = 1'b1;
        xf = 0;
        for (int c = 0; c < 30 && xf < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid && out_ready) xf++;
        end
        chk("midrst words before reset", xf, 2);
        @(negedge clk);
        #1;
        chk("midrst valid before reset", int'(out_valid), 1);
        chk("midrst data before reset", int'(out_data), int'(mem[2]));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst mem_re", int'(mem_re), 0);
        chk("midrst mem_addr", int'(mem_addr), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_data", int'(out_data), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        rst = 1'b0;
        xf = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (done || out_valid || mem_re) xf++;
        end
        chk("midrst quiet after reset", xf, 0);
        run_vec(6, '{len: 2, mode: 0, mid: 0, exp_words: 2, exp_first: 2, exp_done: 4});

`ifdef CHECKSUM_EN
        // Checksum of {F0,20,01} wraps to 0x11; cleared by the next start.
        mem[0] = 8'hF0;
        mem[1] = 8'h20;
        mem[2] = 8'h01;
        @(negedge clk);
        start = 1'b1;
        len = 4'd3;
        out_ready = 1'b1;
        xf = 0;
        for (int c = 0; c < 30 && xf == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                xf = 1;
                chk("chk_out at done", int'(chk_out), 'h11);
            end
        end
        chk("chk done seen", xf, 1);
        @(negedge clk);
        #1;
        chk("chk_out held", int'(chk_out), 'h11);
        start = 1'b1;
        len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("chk_out cleared on start", int'(chk_out), 0);
        repeat (6) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
